instruction_hazard_controller: RTL
==================================

INSTRUCTION_HAZARD_CONTROLLER -- requirements
Module: instruction_hazard_controller

Interface
REQ-001 SHALL have parameter: STALL_CNT_W, 16, width of the stall-cycle performance counter.
REQ-002 SHALL have ports; clock and reset are listed first:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  the ID stage holds a real instruction.
- id_ra  in  5  source register A of the ID instruction (instruc[25:21]).
- id_rb  in  5  source register B of the ID instruction (instruc[20:16]).
- id_uses_rb  in  1  the ID instruction reads rb.
- id_is_branch  in  1  the ID instruction is a branch resolved in ID by the register comparer.
- branch_sel  in  1  taken-branch select from the decode stage.
- ex_rw  in  5  destination register in EX.
- ex_reg_write  in  1  the EX instruction writes a register.
- ex_mem_read  in  1  the EX instruction is a load.
- mem_rw  in  5  destination register in MEM.
- mem_reg_write  in  1  the MEM instruction writes a register.
- mem_mem_read  in  1  the MEM instruction is a load.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clears IF/ID to a NOP.
- idex_bubble  out  1  forces ID/EX control fields (EX/M/WB) to zero.
- stall_cycles  out  STALL_CNT_W  saturating count of stall cycles.
- state  out  2  current FSM state, for debug.
REQ-003 SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 SHALL never flag a match on register 0: any rw equal to 0 causes no hazard.
REQ-005 SHALL define match(x) as (x==id_ra) or (id_uses_rb and x==id_rb).
REQ-006 SHALL define these hazard terms, each qualified by id_valid:
- H_LU = ex_mem_read & ex_reg_write & match(ex_rw).
- H_BE = id_is_branch & ex_reg_write & !ex_mem_read & match(ex_rw).
- H_BM = id_is_branch & mem_mem_read & mem_reg_write & match(mem_rw).
- H_BL = id_is_branch & H_LU.
REQ-007 SHALL have FSM states RUN=0, STALL1=1; encodings 2 and 3 are illegal and SHALL go to RUN.
REQ-008 In RUN, if any of H_LU, H_BE or H_BM holds, the block SHALL stall in the same cycle (combinational): pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
REQ-009 In RUN, the next state SHALL be STALL1 if H_BL holds, otherwise RUN.
REQ-010 STALL1 SHALL stall unconditionally, ignore all hazard and branch inputs, and return to RUN.
REQ-011 Resulting stall counts SHALL be:
- load-use: 1 cycle.
- branch on an ALU result in EX: 1 cycle.
- branch on a load in EX: 2 cycles.
- branch on a load in MEM: 1 cycle.
REQ-012 In RUN with no hazard, and with id_valid, id_is_branch and branch_sel all high, the block SHALL assert ifid_flush=1 for that cycle, with pc_write=1, ifid_write=1 and idex_bubble=0.
REQ-013 branch_sel SHALL be ignored whenever a stall is asserted, because the operands are stale.
REQ-014 With no stall and no flush, outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
REQ-015 stall_cycles SHALL increment by 1 at each clock edge where idex_bubble=1, and SHALL saturate at 2^STALL_CNT_W-1 with no wrap.
REQ-016 If a hazard and a taken branch occur together, the stall SHALL win; the flush occurs only in the later non-stall cycle in which the branch resolves.

Reset
REQ-017 While reset=1, at each clock edge the block SHALL load state=RUN and stall_cycles=0.
REQ-018 While reset=1, outputs SHALL be forced to pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, whatever the inputs.
REQ-019 A reset asserted in STALL1 SHALL abort the stall; the block SHALL be in RUN in the first cycle after reset deasserts.

Structure
REQ-020 A shared package hazard_pkg SHALL hold the state encodings RUN/STALL1 and the constant REG_ZERO=5'd0.
REQ-021 A single sub-module hazard_cmp SHALL compute match(x) and the zero check; it SHALL be instantiated twice, once for ex_rw and once for mem_rw.
REQ-022 The FSM state register and the counter register SHALL be the only storage.

Verification
REQ-023 SHALL run these directed scenarios:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rw=5, id_ra=5 -> one cycle of pc_write=0 and idex_bubble=1, then RUN, stall_cycles=1.
- Branch on load: id_is_branch=1, ex load to r7, id_rb=7, id_uses_rb=1 -> two stall cycles (state 0 then 1), then RUN, stall_cycles=2.
- Zero register: ex load with ex_rw=0, id_ra=0 -> no stall, pc_write=1.
- Taken branch: no hazard, id_is_branch=1, branch_sel=1 -> ifid_flush=1 for exactly one cycle, idex_bubble=0.
- Reset in STALL1: reset=1 for one cycle -> state=0, stall_cycles=0, and normal outputs the next cycle.
- Saturation: with STALL_CNT_W=2, four consecutive load-use stalls -> stall_cycles holds at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM encodings and
// the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL1 = 2'd1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one in-flight destination register against the ID sources.
// A destination of r0 never matches because r0 is never really written.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] rw,
  input  logic [4:0] id_ra,
  input  logic [4:0] id_rb,
  input  logic       id_uses_rb,
  output logic       match
);

  logic nonzero_s;
  logic ra_hit_s;
  logic rb_hit_s;

  assign nonzero_s = (rw != REG_ZERO);
  assign ra_hit_s  = (rw == id_ra);
  assign rb_hit_s  = id_uses_rb & (rw == id_rb);
  assign match     = nonzero_s & (ra_hit_s | rb_hit_s);

endmodule

// File: rtl/instruction_hazard_controller.sv
// Detects load-use and branch-operand hazards in ID, stalls or flushes the
// front end, and counts stall cycles with a saturating counter.
module instruction_hazard_controller
  import hazard_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_ra,
  input  logic [4:0]             id_rb,
  input  logic                   id_uses_rb,
  input  logic                   id_is_branch,
  input  logic                   branch_sel,
  input  logic [4:0]             ex_rw,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic [4:0]             mem_rw,
  input  logic                   mem_reg_write,
  input  logic                   mem_mem_read,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [1:0]             state
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [STALL_CNT_W-1:0] stall_cnt_r;
  logic                   ex_match_s;
  logic                   mem_match_s;
  logic                   h_lu_s;
  logic                   h_be_s;
  logic                   h_bm_s;
  logic                   h_bl_s;
  logic                   stall_s;

  hazard_cmp u_cmp_ex (
    .rw         (ex_rw),
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_uses_rb (id_uses_rb),
    .match      (ex_match_s)
  );

  hazard_cmp u_cmp_mem (
    .rw         (mem_rw),
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_uses_rb (id_uses_rb),
    .match      (mem_match_s)
  );

  // Hazard terms; a branch on a load still in EX needs a second stall cycle
  always_comb begin
    h_lu_s = id_valid & ex_mem_read & ex_reg_write & ex_match_s;
    h_be_s = id_valid & id_is_branch & ex_reg_write & ~ex_mem_read & ex_match_s;
    h_bm_s = id_valid & id_is_branch & mem_mem_read & mem_reg_write & mem_match_s;
    h_bl_s = id_is_branch & h_lu_s;
  end

  // Next state and stall decision; unknown encodings stall once and recover to RUN
  always_comb begin
    state_nxt_s = RUN;
    stall_s     = 1'b1;
    case (state_r)
      RUN: begin
        stall_s = h_lu_s | h_be_s | h_bm_s;
        if (h_bl_s) begin
          state_nxt_s = STALL1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STALL1: begin
        stall_s     = 1'b1;
        state_nxt_s = RUN;
      end
      default: begin
        stall_s     = 1'b1;
        state_nxt_s = RUN;
      end
    endcase
  end

  // Pipeline controls: reset beats stall, stall beats a taken-branch flush
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (stall_s) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_valid & id_is_branch & branch_sel) begin
      ifid_flush  = 1'b1;
    end else begin
      ifid_flush  = 1'b0;
    end
  end

  // State register and saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RUN;
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (idex_bubble && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign state        = state_r;

endmodule
